// File: rtl/dct_pkg.sv
`default_nettype none
// ============================================================================
// Package : dct_pkg
// Brief   : Shared FSM encoding, Q1.14 constants and the 8-point DCT-II table.
// Rev     : 1.0  initial release
// ============================================================================
package dct_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_MAC   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam int COEF_FRAC = 14;
    localparam int COEF_ONE  = 1 << COEF_FRAC;

    // Row k holds round(2^14 * a_k * cos((2n+1)k*pi/16)) for n = 0..7.
    localparam logic signed [15:0] COEF_TABLE [64] = '{
         16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,
         16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598, -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035,
         16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568, -16'sd7568, -16'sd3135,  16'sd3135,  16'sd7568,
         16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551,  16'sd4551,  16'sd8035,  16'sd1598, -16'sd6811,
         16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,  16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,
         16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811, -16'sd6811, -16'sd1598,  16'sd8035, -16'sd4551,
         16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135, -16'sd3135,  16'sd7568, -16'sd7568,  16'sd3135,
         16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035,  16'sd8035, -16'sd6811,  16'sd4551, -16'sd1598
    };

    // Returns {found, index} of the lowest set mask bit at or above i_from.
    function automatic logic [3:0] first_set_from(input logic [7:0] i_mask, input logic [3:0] i_from);
        logic [3:0] w_hit;
        w_hit = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (i_mask[i] && (i >= int'(i_from))) begin
                w_hit = {1'b1, 3'(i)};
            end
        end
        return w_hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dct_stream_core_if.sv
`default_nettype none
// ============================================================================
// Interface : dct_stream_core_if
// Brief     : Input vector and output coefficient handshake bundle.
// Rev       : 1.0  initial release
// ============================================================================
interface dct_stream_core_if #(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int OW = 19
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N*DW-1:0]      in_data;
    logic [N-1:0]         coef_mask;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic [2:0]           out_idx;
    logic                 out_last;

    modport slave (
        input  in_valid, in_data, coef_mask, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

    modport master (
        output in_valid, in_data, coef_mask, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface
`default_nettype wire

// File: rtl/dct_coef_rom.sv
`default_nettype none
// ============================================================================
// Module : dct_coef_rom
// Brief  : Registered coefficient lookup addressed by {k, n}.
// Rev    : 1.0  initial release
// ============================================================================
module dct_coef_rom
    import dct_pkg::*;
#(
    parameter int CW = 16
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire [5:0]            i_addr,
    output logic signed [CW-1:0] o_coef
);

    logic signed [CW-1:0] r_coef;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coef <= '0;
        end else begin
            r_coef <= CW'(COEF_TABLE[i_addr]);
        end
    end

    assign o_coef = r_coef;

endmodule
`default_nettype wire

// File: rtl/dct_stream_core.sv
`default_nettype none
// ============================================================================
// Module : dct_stream_core
// Brief  : Serial 8-point DCT-II, one MAC per cycle, emits requested X[k].
// Rev    : 1.0  initial release
// ============================================================================
module dct_stream_core
    import dct_pkg::*;
#(
    parameter int N    = 8,
    parameter int DW   = 8,
    parameter int CW   = 16,
    parameter int FRAC = 14,
    parameter int OW   = 19
) (
    input  wire              clk,
    input  wire              rst,
    dct_stream_core_if.slave bus
);

    localparam int c_prod_w = DW + CW;
    localparam int c_acc_w  = DW + CW + 3;
    localparam logic signed [c_acc_w-1:0] c_round   = c_acc_w'(64'sd1 <<< (FRAC - 1));
    localparam logic signed [c_acc_w-1:0] c_out_max = c_acc_w'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [c_acc_w-1:0] c_out_min = c_acc_w'(-(64'sd1 <<< (OW - 1)));

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N*DW-1:0]       r_data;
    logic [N-1:0]          r_mask;
    logic [2:0]            r_k;
    logic [2:0]            r_n;
    logic signed [c_acc_w-1:0] r_acc;
    logic signed [OW-1:0]  r_out_data;
    logic [2:0]            r_out_idx;
    logic                  r_out_last;

    logic                  w_accept;
    logic                  w_out_hs;
    logic                  w_mac_done;
    logic [3:0]            w_first;
    logic [3:0]            w_next;
    logic [5:0]            w_rom_addr;
    logic signed [CW-1:0]  w_coef;
    logic signed [DW-1:0]  w_x_n;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [c_acc_w-1:0]  w_acc_nxt;
    logic signed [c_acc_w-1:0]  w_shift;
    logic signed [OW-1:0]  w_sat;

    assign w_accept   = bus.in_valid && (r_state == S_IDLE);
    assign w_out_hs   = (r_state == S_OUT) && bus.out_ready;
    assign w_mac_done = (r_state == S_MAC) && (r_n == 3'(N - 1));
    assign w_first    = first_set_from(bus.coef_mask, 4'd0);
    assign w_next     = first_set_from(r_mask, {1'b0, r_k} + 4'd1);

    // During MAC the ROM is always one tap ahead of the multiplier.
    assign w_rom_addr = (r_state == S_MAC) ? {r_k, 3'(r_n + 3'd1)} : {r_k, 3'd0};

    dct_coef_rom #(
        .CW (CW)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .i_addr (w_rom_addr),
        .o_coef (w_coef)
    );

    assign w_x_n     = $signed(r_data[int'(r_n)*DW +: DW]);
    assign w_prod    = c_prod_w'(w_x_n) * c_prod_w'(w_coef);
    assign w_acc_nxt = r_acc + c_acc_w'(w_prod);
    assign w_shift   = (w_acc_nxt + c_round) >>> FRAC;

    always_comb begin
        w_sat = OW'(w_shift);
        if (w_shift > c_out_max) begin
            w_sat = OW'(c_out_max);
        end else if (w_shift < c_out_min) begin
            w_sat = OW'(c_out_min);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_first[3]) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_MAC;
            S_MAC:   if (w_mac_done) w_state_nxt = S_OUT;
            S_OUT:   if (w_out_hs) w_state_nxt = r_out_last ? S_IDLE : S_FETCH;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data     <= '0;
            r_mask     <= '0;
            r_k        <= 3'd0;
            r_n        <= 3'd0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_out_idx  <= 3'd0;
            r_out_last <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_data <= bus.in_data;
                        r_mask <= bus.coef_mask;
                        r_k    <= w_first[2:0];
                    end
                end
                S_FETCH: begin
                    r_acc <= '0;
                    r_n   <= 3'd0;
                end
                S_MAC: begin
                    r_acc <= w_acc_nxt;
                    r_n   <= 3'(r_n + 3'd1);
                    if (w_mac_done) begin
                        r_out_data <= w_sat;
                        r_out_idx  <= r_k;
                        r_out_last <= ~w_next[3];
                    end
                end
                S_OUT: begin
                    if (w_out_hs) begin
                        r_k <= w_next[2:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_dct_stream_core.sv
`default_nettype none
// ============================================================================
// Module : tb_dct_stream_core
// Brief  : Directed table-driven bench for dct_stream_core.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dct_stream_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dct_stream_core_if #(.N(8), .DW(8), .OW(19)) if0 ();
    dct_stream_core_if #(.N(8), .DW(8), .OW(8))  if8 ();

    dct_stream_core #(.N(8), .DW(8), .CW(16), .FRAC(14), .OW(19)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    dct_stream_core #(.N(8), .DW(8), .CW(16), .FRAC(14), .OW(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    typedef struct {
        logic [7:0][7:0]  x;
        logic [7:0]       mask;
        logic [7:0][31:0] exp;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [7:0][31:0] e8(input int a0, input int a1, input int a2, input int a3,
                                            input int a4, input int a5, input int a6, input int a7);
        logic [7:0][31:0] r;
        r[0] = 32'(a0); r[1] = 32'(a1); r[2] = 32'(a2); r[3] = 32'(a3);
        r[4] = 32'(a4); r[5] = 32'(a5); r[6] = 32'(a6); r[7] = 32'(a7);
        return r;
    endfunction

    function automatic vec_t mk(input logic [63:0] x, input logic [7:0] m, input logic [7:0][31:0] e);
        vec_t v;
        v.x = x; v.mask = m; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] x, input logic [7:0] m, output int t_drive);
        int n = 0;
        while (!if0.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_in_ready", int'(if0.in_ready), 1);
        if0.in_data   = x;
        if0.coef_mask = m;
        if0.in_valid  = 1'b1;
        t_drive = cyc;
        tick();
        if0.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (!if0.out_valid && n < 40) begin
            tick();
            n++;
        end
        ok = if0.out_valid;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int t_drive;
        int t_prev = 0;
        bit ok;
        bit first = 1'b1;
        send(v.x, v.mask, t_drive);
        for (int k = 0; k < 8; k++) begin
            if (v.mask[k]) begin
                wait_valid(ok);
                if (!ok) return;
                if (first) chk($sformatf("v%0d_latency", id), cyc - t_drive, 10);
                else       chk($sformatf("v%0d_spacing_k%0d", id, k), cyc - t_prev, 10);
                first  = 1'b0;
                t_prev = cyc;
                chk($sformatf("v%0d_idx_k%0d", id, k), int'(if0.out_idx), k);
                chk($sformatf("v%0d_data_k%0d", id, k), int'(if0.out_data), $signed(v.exp[k]));
                chk($sformatf("v%0d_last_k%0d", id, k), int'(if0.out_last), ((v.mask >> (k + 1)) == 8'd0) ? 1 : 0);
                chk($sformatf("v%0d_in_ready_busy_k%0d", id, k), int'(if0.in_ready), 0);
                tick();
            end
        end
    endtask

    task automatic run_sat(input logic [63:0] x, input int exp, input string name);
        int n = 0;
        if8.in_data   = x;
        if8.coef_mask = 8'h01;
        if8.in_valid  = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        while (!if8.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_valid"}, int'(if8.out_valid), 1);
        chk(name, int'(if8.out_data), exp);
        tick();
    endtask

    initial begin
        int t;
        int seen;
        if0.in_valid = 1'b0; if0.in_data = '0; if0.coef_mask = '0; if0.out_ready = 1'b1;
        if8.in_valid = 1'b0; if8.in_data = '0; if8.coef_mask = '0; if8.out_ready = 1'b1;

        tbl[0] = mk({8{8'd10}},             8'h01, e8(28, 0, 0, 0, 0, 0, 0, 0));
        tbl[1] = mk({8{8'd10}},             8'hFF, e8(28, 0, 0, 0, 0, 0, 0, 0));
        tbl[2] = mk({56'd0, 8'd127},        8'h06, e8(0, 62, 59, 0, 0, 0, 0, 0));
        tbl[3] = mk({56'd0, 8'd127},        8'h81, e8(45, 0, 0, 0, 0, 0, 0, 12));
        tbl[4] = mk(64'h0706050403020100,   8'h03, e8(10, -6, 0, 0, 0, 0, 0, 0));
        tbl[5] = mk({8{8'hFF}},             8'h01, e8(-3, 0, 0, 0, 0, 0, 0, 0));
        tbl[6] = mk({4{8'h9C, 8'h64}},      8'h81, e8(0, 0, 0, 0, 0, 0, 0, 256));
        tbl[7] = mk({8{8'd127}},            8'h01, e8(359, 0, 0, 0, 0, 0, 0, 0));
        tbl[8] = mk({8{8'h80}},             8'h01, e8(-362, 0, 0, 0, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(if0.out_valid), 0);
        chk("rst_out_data",  int'(if0.out_data), 0);
        chk("rst_out_idx",   int'(if0.out_idx), 0);
        chk("rst_out_last",  int'(if0.out_last), 0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", int'(if0.in_ready), 1);

        for (int i = 0; i < 9; i++) begin
            run_vec(tbl[i], i);
        end

        // Backpressure: result must hold for 20 stalled cycles.
        if0.out_ready = 1'b0;
        send({8{8'd10}}, 8'h01, t);
        begin
            bit ok;
            wait_valid(ok);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("stall_valid_c%0d", i), int'(if0.out_valid), 1);
            chk($sformatf("stall_data_c%0d", i), int'(if0.out_data), 28);
        end
        if0.out_ready = 1'b1;
        tick();
        chk("stall_release_valid", int'(if0.out_valid), 0);
        chk("stall_release_in_ready", int'(if0.in_ready), 1);

        // Reset in the middle of a MAC pass drops the whole vector.
        send({8{8'd10}}, 8'hFF, t);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(if0.out_valid), 0);
        chk("midrst_out_data", int'(if0.out_data), 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("midrst_in_ready", int'(if0.in_ready), 1);
        seen = 0;
        repeat (15) begin
            tick();
            if (if0.out_valid) seen++;
        end
        chk("midrst_no_output", seen, 0);
        run_vec(tbl[4], 20);

        run_sat({8{8'h80}}, -128, "sat_neg");
        run_sat({8{8'd127}}, 127, "sat_pos");

        send({8{8'd10}}, 8'h00, t);
        seen = 0;
        repeat (15) begin
            if (if0.out_valid) seen++;
            tick();
        end
        chk("mask0_no_output", seen, 0);
        chk("mask0_in_ready", int'(if0.in_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dct_stream_core.md
DCT_STREAM_CORE -- requirements
Module: dct_stream_core

Interface
REQ-001 Parameter N, default 8, meaning transform length; only 8 is supported.
REQ-002 Parameter DW, default 8, meaning signed input sample width.
REQ-003 Parameter CW, default 16, meaning signed coefficient width, Q1.14.
REQ-004 Parameter FRAC, default 14, meaning the right-shift applied to the accumulator before output.
REQ-005 Parameter OW, default 19, meaning signed output width after saturation.
REQ-006 Port `clk`, input, 1 bit, the single clock; all logic is rising-edge triggered.
REQ-007 Port `rst`, input, 1 bit; reset is asynchronous and active-high.
REQ-008 Port `in_valid`, input, 1 bit, meaning an input vector is offered.
REQ-009 Port `in_ready`, output, 1 bit, meaning the core can accept a vector.
REQ-010 Port `in_data`, input, N*DW bits, meaning samples x[0..N-1], with x[0] in the LSBs.
REQ-011 Port `coef_mask`, input, N bits, meaning bit k requests coefficient X[k].
REQ-012 Port `out_valid`, output, 1 bit, meaning a result is presented.
REQ-013 Port `out_ready`, input, 1 bit, meaning downstream accepts the result.
REQ-014 Port `out_data`, output, OW bits, signed coefficient value.
REQ-015 Port `out_idx`, output, 3 bits, meaning the index k of `out_data`.
REQ-016 Port `out_last`, output, 1 bit, meaning the final requested coefficient of the vector.

Function
REQ-017 The core SHALL implement FSM states IDLE, FETCH, MAC and OUT.
REQ-018 In IDLE, `in_ready` SHALL be 1; in all other states `in_ready` SHALL be 0.
REQ-019 On `in_valid` && `in_ready`:
- capture `in_data` and `coef_mask`;
- if the mask is nonzero, go to FETCH with k = lowest set mask bit;
- if the mask is zero, stay in IDLE and produce no output.
REQ-020 FETCH SHALL:
- clear the accumulator;
- issue the coefficient ROM read for (k, n=0), the ROM having a 1-cycle registered read;
- last 1 cycle, then go to MAC.
REQ-021 MAC SHALL:
- last exactly N cycles;
- add x[n]*C[k][n] to the accumulator each cycle, n = 0..N-1;
- prefetch C[k][n+1] each cycle;
- go to OUT after n = N-1.
REQ-022 The accumulator SHALL be DW+CW+3 bits wide, and the products SHALL be full-precision signed.
REQ-023 The result SHALL be (acc + 2^(FRAC-1)) >>> FRAC, saturated to the signed OW range [-2^(OW-1), 2^(OW-1)-1].
REQ-024 In OUT:
- `out_valid` SHALL be 1;
- `out_data`, `out_idx` and `out_last` SHALL be stable until `out_valid` && `out_ready`;
- `out_last` = 1 iff no higher set bit remains in the captured mask.
REQ-025 On the OUT handshake, the core SHALL go to FETCH for the next set mask bit, or to IDLE if `out_last` = 1.
REQ-026 Latency SHALL be N+2 cycles from the accepting edge to the first `out_valid`; each further coefficient SHALL take N+2 cycles after the previous handshake.
REQ-027 While `out_ready` = 0 in OUT, the state and outputs SHALL hold indefinitely, with no data loss.
REQ-028 Coefficients SHALL be C[k][n] = round(2^14 * a_k * cos((2n+1)k*pi/16)), with a_0 = sqrt(1/8) and a_k = 1/2 for k > 0.
- C[0][n] = 5793.
- C[1][0] = 8035.

Reset
REQ-029 Asserting `rst` SHALL force IDLE, `out_valid` = 0, `out_data` = 0, `out_idx` = 0, `out_last` = 0, the accumulator = 0 and the captured mask = 0.
REQ-030 `in_ready` SHALL be 1 from the first clock after `rst` deasserts.
REQ-031 Reset asserted mid-vector SHALL discard the in-flight vector and all pending coefficients.

Structure
REQ-032 A shared package `dct_pkg` SHALL hold:
- the FSM state enum;
- the Q1.14 constant;
- the 64-entry coefficient table.
REQ-033 Sub-module `dct_coef_rom` SHALL provide the registered coefficient lookup by 6-bit address {k, n}.

Verification
REQ-034 All x = 10, mask = 8'h01, `out_ready` = 1 -> one output: `out_data` = 28, `out_idx` = 0, `out_last` = 1, `out_valid` rising 10 cycles after acceptance.
REQ-035 All x = 10, mask = 8'hFF -> eight outputs in k order 0..7 with values 28,0,0,0,0,0,0,0, `out_last` set only with k = 7, and `in_ready` = 0 throughout.
REQ-036 x = {127, 0, 0, 0, 0, 0, 0, 0} (x[0] = 127), mask = 8'h06 -> `out_idx` 1 then 2, with `out_data` = round(127*8035/16384) = 62 and round(127*C[2][0]/16384), cross-checked against the reference model.
REQ-037 mask = 8'h01 with `out_ready` held 0 for 20 cycles -> `out_valid` stays 1 and `out_data` is unchanged; the result is accepted on the first `out_ready` = 1, and the core then returns to IDLE.
REQ-038 OW = 8 override, all x = -128, mask = 8'h01 -> `out_data` = -128 (saturated from -362).
REQ-039 `rst` pulsed during MAC of a mask = 8'hFF vector -> `out_valid` stays 0 and `in_ready` = 1 after reset; a new vector then gives correct results; mask = 0 is accepted with no output.
